inst_fetch: RTL and testbench

// - Instruction-fetch front end: owns the program counter and drives the address into the

---
 rtl/inst_fetch_pkg.sv | 19 +
 rtl/inst_fetch_if.sv | 54 +++++
 rtl/inst_fetch_pc_next.sv | 38 +++
 rtl/inst_fetch.sv | 88 ++++++++
 tb/tb_inst_fetch.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// The default widths are used by the interface, the PC sub-module and the top.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int PC_W      = 10;
  localparam int INST_W    = 9;
  localparam int CNT_W_DEF = 16;
  localparam int OFF_W     = 8;

  // The all-ones opcode stops the program.
  localparam logic [INST_W-1:0] HALT_OP = '1;

endpackage

// File: rtl/inst_fetch_if.sv
// Control/ROM bundle between the fetch unit and its surroundings.
// The master modport is the fetch unit, which drives the ROM address and the status outputs.
interface inst_fetch_if
  import inst_fetch_pkg::*;
#(
  parameter int A     = PC_W,
  parameter int W     = INST_W,
  parameter int CNT_W = CNT_W_DEF
);

  logic             start;
  logic [A-1:0]     start_addr;
  logic             stall;
  logic             branch_taken;
  logic             branch_abs;
  logic [A-1:0]     target;
  logic [OFF_W-1:0] offset;
  logic [W-1:0]     inst_in;
  logic [A-1:0]     inst_address;
  logic             inst_valid;
  logic             done;
  logic [CNT_W-1:0] inst_count;

  modport master (
    input  start,
    input  start_addr,
    input  stall,
    input  branch_taken,
    input  branch_abs,
    input  target,
    input  offset,
    input  inst_in,
    output inst_address,
    output inst_valid,
    output done,
    output inst_count
  );

  modport slave (
    output start,
    output start_addr,
    output stall,
    output branch_taken,
    output branch_abs,
    output target,
    output offset,
    output inst_in,
    input  inst_address,
    input  inst_valid,
    input  done,
    input  inst_count
  );

endinterface

// File: rtl/inst_fetch_pc_next.sv
// Combinational next-PC: sequential increment or branch redirect (absolute or
// sign-extended relative), all arithmetic wrapping modulo 2**A.
module inst_fetch_pc_next
  import inst_fetch_pkg::*;
#(
  parameter int A = PC_W
) (
  input  logic [A-1:0]     pc,
  input  logic             branch_taken,
  input  logic             branch_abs,
  input  logic [A-1:0]     target,
  input  logic [OFF_W-1:0] offset,
  output logic [A-1:0]     pc_next
);

  logic [A-1:0] offset_ext;

  genvar gi;
  generate
    if (A >= OFF_W) begin : g_ext
      assign offset_ext[OFF_W-1:0] = offset;
      for (gi = OFF_W; gi < A; gi++) begin : g_sign
        assign offset_ext[gi] = offset[OFF_W-1];
      end
    end else begin : g_trunc
      // A narrower PC simply keeps the low offset bits; the wrap is identical.
      assign offset_ext = offset[A-1:0];
    end
  endgenerate

  always_comb begin
    pc_next = pc + A'(1);
    if (branch_taken) begin
      pc_next = branch_abs ? target : pc + offset_ext;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: PC register, IDLE/RUN/DONE sequencing, halt
// detection and a saturating retired-instruction counter.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int A     = PC_W,
  parameter int W     = INST_W,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic          clk,
  input logic          reset,
  inst_fetch_if.master bus
);

  fetch_state_t     state_reg;
  logic [A-1:0]     pc_reg;
  logic [A-1:0]     pc_next;
  logic             done_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             is_halt;

  generate
    if (W == INST_W) begin : g_halt_pkg
      assign is_halt = (bus.inst_in == HALT_OP);
    end else begin : g_halt_generic
      assign is_halt = &bus.inst_in;
    end
  endgenerate

  inst_fetch_pc_next #(
    .A (A)
  ) u_pc_next (
    .pc           (pc_reg),
    .branch_taken (bus.branch_taken),
    .branch_abs   (bus.branch_abs),
    .target       (bus.target),
    .offset       (bus.offset),
    .pc_next      (pc_next)
  );

  // Counter sticks at all-ones instead of wrapping.
  assign count_next = (&count_reg) ? count_reg : count_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      done_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            state_reg <= RUN;
            pc_reg    <= bus.start_addr;
            done_reg  <= 1'b0;
            count_reg <= '0;
          end
        end
        RUN: begin
          // Stall freezes everything; halt outranks any branch in the same cycle.
          if (!bus.stall) begin
            count_reg <= count_next;
            if (is_halt) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              pc_reg <= pc_next;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          pc_reg    <= '0;
          done_reg  <= 1'b0;
          count_reg <= '0;
        end
      endcase
    end
  end

  assign bus.inst_address = pc_reg;
  assign bus.inst_valid   = (state_reg == RUN) && !bus.stall;
  assign bus.done         = done_reg;
  assign bus.inst_count   = count_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus random traffic,
// with a behavioural PC/count model feeding a fetch scoreboard.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int AW   = 10;
  localparam int NPC  = 1024;
  localparam int CW   = 16;
  localparam int CMAX = 65535;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic clk;
  logic reset;
  logic force_halt;
  logic [INST_W-1:0] rom [NPC];

  inst_fetch_if #(.A(AW), .W(INST_W), .CNT_W(CW)) bus ();

  inst_fetch #(.A(AW), .W(INST_W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.inst_in = force_halt ? HALT_OP : rom[bus.inst_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  int m_state;
  int m_pc;
  int m_count;
  bit m_valid;

  int exp_addr [$];
  int exp_cnt  [$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int wrap_pc(input int v);
    return ((v % NPC) + NPC) % NPC;
  endfunction

  function automatic int signed_off(input int off);
    return (off >= 128) ? off - 256 : off;
  endfunction

  // Monitor: every live fetch consumes one scoreboard entry.
  always @(negedge clk) begin
    if (checking && bus.inst_valid === 1'b1) begin
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch: got fetch at addr %0d, expected no fetch", bus.inst_address);
      end else begin
        int a;
        int c;
        a = exp_addr.pop_front();
        c = exp_cnt.pop_front();
        $display("fetch addr=%0d count=%0d (exp addr=%0d count=%0d)", bus.inst_address, bus.inst_count, a, c);
        check("fetch_addr", 32'(bus.inst_address), 32'(a));
        check("fetch_count", 32'(bus.inst_count), 32'(c));
      end
    end
  end

  task automatic check_state();
    check("pc", 32'(bus.inst_address), 32'(m_pc));
    check("done", 32'(bus.done), 32'(m_state == M_DONE));
    check("count", 32'(bus.inst_count), 32'(m_count));
    check("valid", 32'(bus.inst_valid), 32'(m_valid));
  endtask

  task automatic cycle(input bit rst, input bit st, input int sa, input bit stl,
                       input bit br, input bit ab, input int tg, input int off, input bit fh);
    bit halt;
    @(posedge clk);
    #1;
    reset            = rst;
    bus.start        = st;
    bus.start_addr   = sa[AW-1:0];
    bus.stall        = stl;
    bus.branch_taken = br;
    bus.branch_abs   = ab;
    bus.target       = tg[AW-1:0];
    bus.offset       = off[7:0];
    force_halt       = fh;
    m_valid = (m_state == M_RUN) && !stl;
    if (m_valid) begin
      exp_addr.push_back(m_pc);
      exp_cnt.push_back(m_count);
    end
    @(negedge clk);
    check_state();
    halt = fh || (rom[m_pc] == HALT_OP);
    if (rst) begin
      m_state = M_IDLE;
      m_pc    = 0;
      m_count = 0;
    end else if (m_state == M_RUN) begin
      if (!stl) begin
        m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
        if (halt)     m_state = M_DONE;
        else if (br)  m_pc = ab ? tg : wrap_pc(m_pc + signed_off(off));
        else          m_pc = wrap_pc(m_pc + 1);
      end
    end else if (st) begin
      m_state = M_RUN;
      m_pc    = sa;
      m_count = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_start(input int sa);
    cycle(0, 1, sa, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_branch(input bit ab, input int tg, input int off);
    cycle(0, 0, 0, 0, 1, ab, tg, off, 0);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fill_plain();
    for (int i = 0; i < NPC; i++) rom[i] = INST_W'(i % 256);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset            = 1'b1;
    force_halt       = 1'b0;
    bus.start        = 1'b0;
    bus.start_addr   = '0;
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_abs   = 1'b0;
    bus.target       = '0;
    bus.offset       = '0;
    fill_plain();
    repeat (3) @(posedge clk);
    m_state  = M_IDLE;
    m_pc     = 0;
    m_count  = 0;
    m_valid  = 1'b0;
    checking = 1'b1;
    do_reset();

    // Straight-line program halting at address 5.
    rom[5] = HALT_OP;
    do_start(0);
    idle(7);
    check("halt_done", 32'(bus.done), 32'd1);
    check("halt_pc", 32'(bus.inst_address), 32'd5);
    check("halt_count", 32'(bus.inst_count), 32'd6);
    idle(2);
    check("halt_pc_hold", 32'(bus.inst_address), 32'd5);
    fill_plain();

    // Absolute branch at PC=2, then Start while running, then reset mid-run.
    do_start(2);
    do_branch(1, 'h3F0, 0);
    idle(1);
    check("abs_branch_pc", 32'(bus.inst_address), 32'h3F0);
    cycle(0, 1, 8, 0, 0, 0, 0, 0, 0);
    idle(1);
    check("start_in_run_pc", 32'(bus.inst_address), 32'h3F2);
    do_reset();
    idle(1);
    check("reset_mid_run_pc", 32'(bus.inst_address), 32'd0);
    check("reset_mid_run_valid", 32'(bus.inst_valid), 32'd0);

    // Relative branch backwards.
    do_start(10);
    do_branch(0, 0, 'hFD);
    idle(1);
    check("rel_neg_pc", 32'(bus.inst_address), 32'd7);

    // Sequential wrap at the top of the address space.
    do_reset();
    do_start(1022);
    idle(1);
    check("wrap_pc0", 32'(bus.inst_address), 32'd1022);
    idle(1);
    check("wrap_pc1", 32'(bus.inst_address), 32'd1023);
    idle(1);
    check("wrap_pc2", 32'(bus.inst_address), 32'd0);

    // Relative branch forwards across the wrap.
    do_reset();
    do_start(1021);
    do_branch(0, 0, 5);
    idle(1);
    check("rel_wrap_pc", 32'(bus.inst_address), 32'd2);

    // Three stall cycles at PC=4, one with a branch and one with a halt opcode.
    do_reset();
    do_start(4);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 1, 100, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 1);
    check("stall_pc", 32'(bus.inst_address), 32'd4);
    check("stall_valid", 32'(bus.inst_valid), 32'd0);
    check("stall_count", 32'(bus.inst_count), 32'd0);
    check("stall_done", 32'(bus.done), 32'd0);
    idle(2);
    check("after_stall_pc", 32'(bus.inst_address), 32'd5);

    // Halt beats a branch in the same cycle; restart from DONE.
    rom[6] = HALT_OP;
    do_reset();
    do_start(6);
    do_branch(1, 100, 0);
    idle(1);
    check("halt_vs_branch_done", 32'(bus.done), 32'd1);
    check("halt_vs_branch_pc", 32'(bus.inst_address), 32'd6);
    do_start(8);
    idle(1);
    check("restart_pc", 32'(bus.inst_address), 32'd8);
    check("restart_done", 32'(bus.done), 32'd0);
    check("restart_count", 32'(bus.inst_count), 32'd0);
    fill_plain();

    // Random traffic against the model.
    for (int i = 0; i < NPC; i++)
      rom[i] = ($urandom_range(0, 63) == 0) ? HALT_OP : INST_W'($urandom_range(0, 510));
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) == 0,
            $urandom_range(0, 9) == 0,
            int'($urandom_range(0, NPC - 1)),
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0,
            1'($urandom_range(0, 1)),
            int'($urandom_range(0, NPC - 1)),
            int'($urandom_range(0, 255)),
            $urandom_range(0, 49) == 0);
    end

    @(posedge clk);
    check("scoreboard_drained", 32'(exp_addr.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
